button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Front-end for the operand-entry controller: turns the raw, bouncing, asynchronous push-button pin into clean single-cycle events.
- Its `press` output drives the controller's `button` input directly, one pulse per physical press.
- Also provides release and long-press events, plus a debounced level for the display/LED logic.

Parameters:
- DEBOUNCE_CYCLES, 10000, consecutive stable synchronized samples needed to accept a level change; legal range ≥2.
- LONG_CYCLES, 500000, cycles in PRESSED before `long_press` fires; 0 disables `long_press`.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- btn_raw  input  1  asynchronous button pin, active-high
- press  output  1  one-cycle pulse on each accepted press
- release_p  output  1  one-cycle pulse on each accepted release
- long_press  output  1  one-cycle pulse, at most once per press
- btn_stable  output  1  debounced button level

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk.
- Reset: all outputs 0, state RELEASED, counters 0, synchronizer flops 0.
- Synchronizer: 2 flops on btn_raw; `btn_sync` is the second flop. No other logic reads btn_raw.
- Counters:
  - deb_cnt, width $clog2(DEBOUNCE_CYCLES).
  - hold_cnt, width $clog2(LONG_CYCLES+1), saturating.
  - long_done flag.
- All outputs are registered.
- FSM, evaluated each clock edge:
  - RELEASED:
    - btn_sync=1 -> PRESS_DEB, deb_cnt<=0.
  - PRESS_DEB:
    - btn_sync=0 -> RELEASED, deb_cnt<=0, no pulse (bounce rejected).
    - btn_sync=1 and deb_cnt==DEBOUNCE_CYCLES-1 -> PRESSED, press<=1 for one cycle, hold_cnt<=0, long_done<=0.
    - otherwise deb_cnt++.
  - PRESSED:
    - btn_sync=0 -> RELEASE_DEB, deb_cnt<=0.
    - else hold_cnt++ (saturating).
    - When LONG_CYCLES≠0, hold_cnt==LONG_CYCLES-1 and !long_done: long_press<=1 for one cycle, long_done<=1.
  - RELEASE_DEB:
    - btn_sync=1 -> PRESSED. deb_cnt<=0; hold_cnt and long_done are kept (a bounce is not a new press, so no `press`).
    - btn_sync=0 and deb_cnt==DEBOUNCE_CYCLES-1 -> RELEASED, release_p<=1 for one cycle, hold_cnt<=0.
    - otherwise deb_cnt++.
- btn_stable = 1 in PRESSED and RELEASE_DEB, else 0 (registered with the state).
- Latency: btn_raw changes before edge 1 and stays stable -> press/release_p high for the cycle after edge DEBOUNCE_CYCLES+3.
- long_press: high for the cycle after edge DEBOUNCE_CYCLES+3+LONG_CYCLES.
- press, release_p and long_press are never high for 2 consecutive cycles.
- press and release_p are never high in the same cycle.
- Within one press, long_press never coincides with press.
- Reset mid-operation: returns to RELEASED immediately with no pulse emitted. If the button is still held, it is re-debounced from scratch and produces a fresh `press`.
- Button held forever: hold_cnt saturates and no repeat pulses are generated.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20 unless stated):
- Clean press: btn_raw=1 before edge 1, held 15 cycles, then 0.
  - press high only after edge 7; btn_stable=1 from edge 7.
  - release_p high only after edge 16+7; no long_press.
- Bounce rejection: btn_raw pulses high 3 cycles, low 1, high 2, then low.
  - press, release_p and btn_stable stay 0 throughout.
- Release bounce: after an accepted press, btn_raw low 2 cycles then high again.
  - No release_p and no second press; btn_stable stays 1.
- Long hold: btn_raw held 60 cycles.
  - Exactly one press after edge 7.
  - Exactly one long_press after edge 27.
  - Then one release_p after the btn_raw falling edge + 7.
- Reset mid-press: rst_n=0 for 2 cycles while PRESSED, btn_raw still 1.
  - Outputs 0 during reset.
  - After release of reset, a new press pulse 7 edges later.
- Integration: conditioner driving the controller, three clean presses.
  - save_A, save_B, show_result each pulse once, in that order.
  - Controller back in its wait-A state.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button front-end. It synchronizes and debounces the raw pin, then emits
// press, release and long-press pulses plus a debounced level.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter int unsigned LONG_CYCLES     = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press,
  output logic release_p,
  output logic long_press,
  output logic btn_stable
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = (LONG_CYCLES == 0) ? 1 : $clog2(LONG_CYCLES + 1);
  localparam bit          LONG_EN = (LONG_CYCLES != 0);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;

  localparam logic [1:0] S_RELEASED    = 2'd0;
  localparam logic [1:0] S_PRESS_DEB   = 2'd1;
  localparam logic [1:0] S_PRESSED     = 2'd2;
  localparam logic [1:0] S_RELEASE_DEB = 2'd3;

  logic [1:0]        sync_q;
  logic              btn_sync;
  logic [1:0]        state, state_nxt;
  logic [DEB_W-1:0]  deb_cnt, deb_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              long_done, done_nxt;
  logic              press_nxt, rel_nxt, long_nxt, stable_nxt;

  assign btn_sync = sync_q[1];

  // Two-flop synchronizer; the only reader of btn_raw.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], btn_raw};
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_RELEASED;
      deb_cnt    <= '0;
      hold_cnt   <= '0;
      long_done  <= 1'b0;
      press      <= 1'b0;
      release_p  <= 1'b0;
      long_press <= 1'b0;
      btn_stable <= 1'b0;
    end else begin
      state      <= state_nxt;
      deb_cnt    <= deb_nxt;
      hold_cnt   <= hold_nxt;
      long_done  <= done_nxt;
      press      <= press_nxt;
      release_p  <= rel_nxt;
      long_press <= long_nxt;
      btn_stable <= stable_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    deb_nxt   = deb_cnt;
    hold_nxt  = hold_cnt;
    done_nxt  = long_done;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    long_nxt  = 1'b0;
    case (state)
      S_RELEASED: begin
        if (btn_sync) begin
          state_nxt = S_PRESS_DEB;
          deb_nxt   = '0;
        end
      end
      S_PRESS_DEB: begin
        if (!btn_sync) begin
          state_nxt = S_RELEASED;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = S_PRESSED;
          press_nxt = 1'b1;
          hold_nxt  = '0;
          done_nxt  = 1'b0;
          deb_nxt   = '0;
        end else begin
          deb_nxt = deb_cnt + DEB_W'(1);
        end
      end
      S_PRESSED: begin
        if (!btn_sync) begin
          state_nxt = S_RELEASE_DEB;
          deb_nxt   = '0;
        end else begin
          if (hold_cnt != HOLD_MAX) hold_nxt = hold_cnt + HOLD_W'(1);
          if (LONG_EN && (hold_cnt == LONG_LAST) && !long_done) begin
            long_nxt = 1'b1;
            done_nxt = 1'b1;
          end
        end
      end
      S_RELEASE_DEB: begin
        // A bounce back to high resumes the same press: hold count and long flag survive.
        if (btn_sync) begin
          state_nxt = S_PRESSED;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = S_RELEASED;
          rel_nxt   = 1'b1;
          hold_nxt  = '0;
          deb_nxt   = '0;
        end else begin
          deb_nxt = deb_cnt + DEB_W'(1);
        end
      end
      default: state_nxt = S_RELEASED;
    endcase
    stable_nxt = (state_nxt == S_PRESSED) || (state_nxt == S_RELEASE_DEB);
  end

endmodule
